alu_stim_driver: RTL and testbench

On-board stimulus initiator for the `mipscpu` ALU port. It drives `data_1`, `data_2` and `sel` through a fixed five-operation script (ADD, SUB, AND, OR, SLT), one run per `key_ok` press. For each step it holds the operands stable for a programmable time, then captures `alu_out` and `alu_zero_flag`. Optionally it checks each capture against an internal reference model and counts mismatches.

---
 rtl/alu_stim_driver.sv | 187 ++++++++++++++++++
 tb/tb_alu_stim_driver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stim_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_stim_driver
// Purpose  : On-board stimulus initiator for the mipscpu ALU port. Each
//            key_ok press runs a fixed five-step script (ADD, SUB, AND, OR,
//            SLT). Every step holds OPA/OPB/sel for HOLD_CYCLES clocks, then
//            captures alu_out into last_result.
// Option   : `define ALU_STIM_SELFCHECK_EN adds a reference model. Each
//            capture is compared against it and err_count (saturating at 7)
//            records the mismatching steps. Without the macro, err_count
//            stays 0 and pass follows done.
// Ports    : clk, rstn (async, active-low), key_ok (raw async level)
//            alu_out, alu_zero_flag    - ALU response
//            data_1, data_2, sel       - ALU stimulus (0 when not driving)
//            busy, done, step          - run status
//            last_result, err_count, pass - capture/self-check results
// Revision : 1.0 - initial release
// ============================================================================
module alu_stim_driver #(
    parameter int                   WORD_SIZE   = 16,
    parameter int                   OP_SIZE     = 4,
    parameter int                   HOLD_CYCLES = 1000,
    parameter logic [WORD_SIZE-1:0] OPA         = 16'h0004,
    parameter logic [WORD_SIZE-1:0] OPB         = 16'h0005
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 key_ok,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_zero_flag,
    output logic [WORD_SIZE-1:0] data_1,
    output logic [WORD_SIZE-1:0] data_2,
    output logic [OP_SIZE-1:0]   sel,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           step,
    output logic [WORD_SIZE-1:0] last_result,
    output logic [2:0]           err_count,
    output logic                 pass
);

    localparam logic [OP_SIZE-1:0] c_OP_AND = OP_SIZE'(4'b0101);
    localparam logic [OP_SIZE-1:0] c_OP_OR  = OP_SIZE'(4'b0110);
    localparam logic [OP_SIZE-1:0] c_OP_ADD = OP_SIZE'(4'b0111);
    localparam logic [OP_SIZE-1:0] c_OP_SUB = OP_SIZE'(4'b1000);
    localparam logic [OP_SIZE-1:0] c_OP_SLT = OP_SIZE'(4'b1001);
    localparam logic [15:0]        c_HOLD_RELOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [2:0]         c_LAST_STEP   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_sync1, r_sync2, r_prev;
    logic [1:0]           r_vld;
    logic                 w_start;
    logic [2:0]           r_step, w_step_nxt;
    logic [15:0]          r_cnt, w_cnt_nxt;
    logic [WORD_SIZE-1:0] r_last, w_last_nxt;
    logic [2:0]           r_err, w_err_nxt;
    logic [OP_SIZE-1:0]   w_script_sel;
    logic                 w_mismatch;
    logic                 w_drive;

    // Synchronizer plus edge detector. r_prev resets high and is only allowed
    // to follow the synchronized level once r_sync2 holds a real sample
    // (r_vld[1]), so a key held high through reset is not mistaken for a press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_vld   <= 2'b00;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= key_ok;
            r_sync2 <= r_sync1;
            r_vld   <= {r_vld[0], 1'b1};
            r_prev  <= r_vld[1] ? r_sync2 : 1'b1;
        end
    end

    assign w_start = r_sync2 & ~r_prev;

    always_comb begin
        case (r_step)
            3'd0:    w_script_sel = c_OP_ADD;
            3'd1:    w_script_sel = c_OP_SUB;
            3'd2:    w_script_sel = c_OP_AND;
            3'd3:    w_script_sel = c_OP_OR;
            default: w_script_sel = c_OP_SLT;
        endcase
    end

`ifdef ALU_STIM_SELFCHECK_EN
    logic [WORD_SIZE-1:0] w_expected;

    always_comb begin
        w_expected = '0;
        case (w_script_sel)
            c_OP_AND: w_expected = OPA & OPB;
            c_OP_OR:  w_expected = OPA | OPB;
            c_OP_ADD: w_expected = OPA + OPB;
            c_OP_SUB: w_expected = OPA - OPB;
            c_OP_SLT: w_expected = ($signed(OPA) < $signed(OPB)) ? WORD_SIZE'(1) : '0;
            default:  w_expected = '0;
        endcase
    end

    assign w_mismatch = (alu_out != w_expected) ||
                        (alu_zero_flag != (w_expected == '0));
`else
    logic w_unused_zero;
    assign w_unused_zero = alu_zero_flag;
    assign w_mismatch    = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_state_nxt = ST_DRIVE;
                    w_step_nxt  = '0;
                    w_cnt_nxt   = c_HOLD_RELOAD;
                    w_last_nxt  = '0;
                    w_err_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else begin
                    // Final edge of the step: capture and advance together so
                    // the next step is driven with no idle gap.
                    w_last_nxt = alu_out;
                    if (w_mismatch && (r_err != 3'd7)) begin
                        w_err_nxt = r_err + 3'd1;
                    end
                    if (r_step == c_LAST_STEP) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_step_nxt = r_step + 3'd1;
                        w_cnt_nxt  = c_HOLD_RELOAD;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_drive     = (r_state == ST_DRIVE);
    assign data_1      = w_drive ? OPA : '0;
    assign data_2      = w_drive ? OPB : '0;
    assign sel         = w_drive ? w_script_sel : '0;
    assign busy        = w_drive;
    assign done        = (r_state == ST_DONE);
    assign step        = r_step;
    assign last_result = r_last;
    assign err_count   = r_err;
    assign pass        = done && (r_err == 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_alu_stim_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_stim_driver
// Purpose  : Directed bench for alu_stim_driver. Two instances are used: one
//            with HOLD_CYCLES=1000 and one with HOLD_CYCLES=2. A behavioural
//            ALU responds to each instance, and a fault can be injected on
//            the OR step of the first instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_stim_driver;

    localparam int H  = 1000;
    localparam int H2 = 2;
`ifdef ALU_STIM_SELFCHECK_EN
    localparam logic [2:0] EXP_ERR = 3'd1;
`else
    localparam logic [2:0] EXP_ERR = 3'd0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        key1, key2, fault_en;
    logic [15:0] alu1, alu2, d1a, d2a, d1b, d2b, last1, last2;
    logic        zero1, zero2, busy1, busy2, done1, done2, pass1, pass2;
    logic [3:0]  sel1, sel2;
    logic [2:0]  step1, step2, err1, err2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  script  [5] = '{4'd7, 4'd8, 4'd5, 4'd6, 4'd9};
    logic [15:0] exp_res [5] = '{16'h0009, 16'hFFFF, 16'h0004, 16'h0005, 16'h0001};

    always #20 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] s);
        case (s)
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a + b;
            4'd8:    return a - b;
            4'd9:    return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    assign alu1  = (fault_en && sel1 == 4'd6) ? 16'h0004 : alu_ref(d1a, d2a, sel1);
    assign zero1 = (alu1 == 16'h0000);
    assign alu2  = alu_ref(d1b, d2b, sel2);
    assign zero2 = (alu2 == 16'h0000);

    alu_stim_driver #(.WORD_SIZE(16), .OP_SIZE(4), .HOLD_CYCLES(H),
                      .OPA(16'h0004), .OPB(16'h0005)) u_dut (
        .clk(clk), .rstn(rstn), .key_ok(key1), .alu_out(alu1), .alu_zero_flag(zero1),
        .data_1(d1a), .data_2(d2a), .sel(sel1), .busy(busy1), .done(done1),
        .step(step1), .last_result(last1), .err_count(err1), .pass(pass1));

    alu_stim_driver #(.WORD_SIZE(16), .OP_SIZE(4), .HOLD_CYCLES(H2),
                      .OPA(16'h0004), .OPB(16'h0005)) u_dut_min (
        .clk(clk), .rstn(rstn), .key_ok(key2), .alu_out(alu2), .alu_zero_flag(zero2),
        .data_1(d1b), .data_2(d2b), .sel(sel2), .busy(busy2), .done(done2),
        .step(step2), .last_result(last2), .err_count(err2), .pass(pass2));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Key low long enough to clear the edge detector, then raised just after
    // a falling edge so the following rising edge is E0.
    task automatic press1();
        key1 = 1'b0;
        tick(5);
        @(negedge clk);
        key1 = 1'b1;
    endtask

    task automatic press2();
        key2 = 1'b0;
        tick(5);
        @(negedge clk);
        key2 = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; key1 = 1'b1; key2 = 1'b1; fault_en = 1'b0;
        #95;
        n_checks++;
        if ({d1a, d2a, sel1, busy1, done1, step1, last1, err1, pass1} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h required 0",
                {d1a, d2a, sel1, busy1, done1, step1, last1, err1, pass1});
        end
        n_checks++;
        if ({d1b, d2b, sel2, busy2, done2, step2, last2, err2, pass2} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_min: got %h required 0",
                {d1b, d2b, sel2, busy2, done2, step2, last2, err2, pass2});
        end
        @(negedge clk);
        rstn = 1'b1;
        tick(20);
        n_checks++;
        if ({busy1, done1, busy2, done2} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_key_held_no_run: got busy/done %b required 0000",
                {busy1, done1, busy2, done2});
        end
    endtask

    task automatic test_golden();
        press1();
        tick(1);
        n_checks++;
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL golden_E0_busy: got %b required 0", busy1); end
        tick(1);
        n_checks++;
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL golden_E1_busy: got %b required 0", busy1); end
        tick(1);
        n_checks++;
        if ({d1a, d2a} !== {16'h0004, 16'h0005}) begin
            n_fail++; $display("FAIL golden_operands: got %h required 00040005", {d1a, d2a});
        end
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if ({busy1, step1, sel1} !== {1'b1, 3'(s), script[s]}) begin
                n_fail++; $display("FAIL golden_step%0d_start: got busy/step/sel %b/%0d/%h required 1/%0d/%h",
                    s, busy1, step1, sel1, s, script[s]);
            end
            tick(H - 1);
            n_checks++;
            if ({sel1, done1} !== {script[s], 1'b0}) begin
                n_fail++; $display("FAIL golden_step%0d_hold: got sel/done %h/%b required %h/0",
                    s, sel1, done1, script[s]);
            end
            tick(1);
            n_checks++;
            if (last1 !== exp_res[s]) begin
                n_fail++; $display("FAIL golden_capture%0d: got %h required %h", s, last1, exp_res[s]);
            end
        end
        n_checks++;
        if ({done1, pass1, err1, busy1, sel1} !== {1'b1, 1'b1, 3'd0, 1'b0, 4'd0}) begin
            n_fail++; $display("FAIL golden_done: got done/pass/err/busy/sel %b/%b/%0d/%b/%h required 1/1/0/0/0",
                done1, pass1, err1, busy1, sel1);
        end
    endtask

    task automatic test_faulty_alu();
        int k;
        fault_en = 1'b1;
        press1();
        tick(3);
        k = 0;
        while (done1 !== 1'b1 && k < 6000) begin tick(1); k++; end
        n_checks++;
        if (k >= 6000) begin n_fail++; $display("FAIL faulty_timeout: got no done required done"); end
        n_checks++;
        if ({err1, pass1} !== {EXP_ERR, (EXP_ERR == 3'd0)}) begin
            n_fail++; $display("FAIL faulty_err: got err/pass %0d/%b required %0d/%b",
                err1, pass1, EXP_ERR, (EXP_ERR == 3'd0));
        end
    endtask

    task automatic test_repress();
        press1();
        tick(3);
        tick(2 * H);
        n_checks++;
        if (step1 !== 3'd2) begin n_fail++; $display("FAIL repress_at_step2: got %0d required 2", step1); end
        tick(10);
        key1 = 1'b0;
        tick(10);
        key1 = 1'b1;
        tick(5 * H - 2 * H - 20 - 1);
        n_checks++;
        if ({done1, sel1, step1} !== {1'b0, 4'd9, 3'd4}) begin
            n_fail++; $display("FAIL repress_before_done: got done/sel/step %b/%h/%0d required 0/9/4",
                done1, sel1, step1);
        end
        tick(1);
        n_checks++;
        if ({done1, err1} !== {1'b1, EXP_ERR}) begin
            n_fail++; $display("FAIL repress_done: got done/err %b/%0d required 1/%0d", done1, err1, EXP_ERR);
        end
        fault_en = 1'b0;
        press1();
        tick(3);
        n_checks++;
        if ({busy1, done1, step1, sel1, err1, last1} !== {1'b1, 1'b0, 3'd0, 4'd7, 3'd0, 16'h0000}) begin
            n_fail++; $display("FAIL rerun_start: got busy/done/step/sel/err/last %b/%b/%0d/%h/%0d/%h required 1/0/0/7/0/0000",
                busy1, done1, step1, sel1, err1, last1);
        end
    endtask

    task automatic test_midrun_reset();
        int k;
        k = 0;
        while (step1 !== 3'd3 && k < 6000) begin tick(1); k++; end
        n_checks++;
        if (k >= 6000) begin n_fail++; $display("FAIL midreset_reach_step3: got step %0d required 3", step1); end
        #5;
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({d1a, d2a, sel1, busy1, done1, step1, last1, err1, pass1} !== '0) begin
            n_fail++; $display("FAIL midreset_async: got %h required 0",
                {d1a, d2a, sel1, busy1, done1, step1, last1, err1, pass1});
        end
        #10;
        rstn = 1'b1;
        press1();
        tick(3);
        n_checks++;
        if ({busy1, step1, sel1} !== {1'b1, 3'd0, 4'd7}) begin
            n_fail++; $display("FAIL midreset_restart: got busy/step/sel %b/%0d/%h required 1/0/7",
                busy1, step1, sel1);
        end
    endtask

    task automatic test_min_hold();
        press2();
        tick(3);
        for (int s = 0; s < 5; s++) begin
            n_checks++;
            if ({busy2, step2, sel2} !== {1'b1, 3'(s), script[s]}) begin
                n_fail++; $display("FAIL minhold_step%0d_start: got busy/step/sel %b/%0d/%h required 1/%0d/%h",
                    s, busy2, step2, sel2, s, script[s]);
            end
            tick(H2 - 1);
            n_checks++;
            if ({sel2, done2} !== {script[s], 1'b0}) begin
                n_fail++; $display("FAIL minhold_step%0d_hold: got sel/done %h/%b required %h/0",
                    s, sel2, done2, script[s]);
            end
            tick(1);
            n_checks++;
            if (last2 !== exp_res[s]) begin
                n_fail++; $display("FAIL minhold_capture%0d: got %h required %h", s, last2, exp_res[s]);
            end
        end
        n_checks++;
        if ({done2, pass2, err2, busy2} !== {1'b1, 1'b1, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL minhold_done: got done/pass/err/busy %b/%b/%0d/%b required 1/1/0/0",
                done2, pass2, err2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_faulty_alu();
        test_repress();
        test_midrun_reset();
        test_min_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
